// File: rtl/sync_ram_pkg.sv
// Shared constants and types for the sync_ram_32 data/instruction store.
// The clear-sweep state type is only used when SYNC_RAM_CLEAR_EN is defined.
package sync_ram_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/sync_ram_clear_ctrl.sv
// Reset-triggered clear sweep for sync_ram_32 (present only under SYNC_RAM_CLEAR_EN).
//
//   state | meaning
//   IDLE  | memory usable, busy low
//   CLEAR | zeroing one word per cycle, busy high
module sync_ram_clear_ctrl
  import sync_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  o_busy,
  output logic                  o_clr_en,
  output logic [ADDR_WIDTH-1:0] o_clr_addr
);

  clr_state_t            r_state;
  clr_state_t            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;

  // State and sweep counter; reset (re)starts the sweep from word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Advance through every word; the last word is written on the way back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      CLEAR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == '1) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_busy     = (r_state == CLEAR);
  assign o_clr_en   = (r_state == CLEAR) && !reset;
  assign o_clr_addr = r_cnt;

endmodule

// File: rtl/sync_ram_32.sv
// Single-port synchronous RAM with a registered, read-first read port.
// Optional feature: define SYNC_RAM_CLEAR_EN to zero the whole array after reset
// (busy is high during the sweep); otherwise busy is tied low and contents are not initialised.
module sync_ram_32
  import sync_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] Din,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  writeEn,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] Dout,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  w_busy;
  logic                  w_clr_en;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_wr_en;
  logic                  w_rd_en;

`ifdef SYNC_RAM_CLEAR_EN
  sync_ram_clear_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_ctrl (
    .clk        (clk),
    .reset      (reset),
    .o_busy     (w_busy),
    .o_clr_en   (w_clr_en),
    .o_clr_addr (w_clr_addr)
  );
`else
  assign w_busy     = 1'b0;
  assign w_clr_en   = 1'b0;
  assign w_clr_addr = '0;
`endif

  // Reset wins over a same-cycle write, and user accesses are locked out during the sweep.
  assign w_wr_en = writeEn && !w_busy && !reset;
  assign w_rd_en = read && !w_busy;

  // Memory array: no reset, so contents survive reset unless the sweep clears them.
  always_ff @(posedge clk) begin
    if (w_clr_en) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_en) begin
      r_mem[addr] <= Din;
    end
  end

  // Read register: samples the pre-write contents, so a same-address write is read-first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout <= '0;
    end else if (w_rd_en) begin
      r_dout <= r_mem[addr];
    end
  end

  assign Dout = r_dout;
  assign busy = w_busy;

endmodule

// File: tb/tb_sync_ram_32.sv
// Scoreboard bench for sync_ram_32 at ADDR_WIDTH=4. Also exercises the clear sweep
// when built with SYNC_RAM_CLEAR_EN.
module tb_sync_ram_32;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          writeEn = 1'b0;
  logic          read = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] Din = '0;
  logic [DW-1:0] Dout;
  logic          busy;

  always #5 clk = ~clk;

  sync_ram_32 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .Din     (Din),
    .addr    (addr),
    .writeEn (writeEn),
    .read    (read),
    .Dout    (Dout),
    .busy    (busy)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: array of words plus the value Dout should hold.
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] model_dout = '0;
  logic [DW-1:0] exp_q [$];
  logic          tb_chk = 1'b0;
  logic [DW-1:0] mon_exp;

  // One clock of stimulus, driven just after a falling edge; the expected Dout is queued.
  task automatic cycle(input logic rst, input logic we, input logic rd,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    reset = rst; writeEn = we; read = rd; addr = a; Din = d;
    if (rst) model_dout = '0;
    else if (rd) model_dout = model_mem[a];
    if (!rst && we) model_mem[a] = d;
    exp_q.push_back(model_dout);
    tb_chk = 1'b1;
    @(negedge clk);
    tb_chk = 1'b0;
    reset = 1'b0; writeEn = 1'b0; read = 1'b0;
  endtask

  // Monitor: for each checked edge, compare Dout shortly after the edge.
  always @(posedge clk) begin
    if (tb_chk) begin
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_underflow: no expected value queued at %0t", $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (Dout !== mon_exp) begin
          failures++;
          $display("FAIL dout at %0t: got %08h expected %08h", $time, Dout, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

`ifdef SYNC_RAM_CLEAR_EN
  // Pulse reset, then count falling-edge samples with busy high. Optionally re-assert
  // reset once the count reaches restart_at, which must restart the count.
  task automatic sweep(input int restart_at, output int n);
    reset = 1'b1; writeEn = 1'b0; read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      if (n == restart_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        restart_at = -1;
        continue;
      end
      check("dout_zero_while_busy", Dout, '0);
      writeEn = 1'b1; read = 1'b1; addr = 4'd3; Din = $urandom;
      n++;
      @(negedge clk);
    end
    writeEn = 1'b0; read = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("sweep_done_in_budget", {31'b0, busy}, '0);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask
`endif

  initial begin
    int n;
    @(negedge clk);
`ifdef SYNC_RAM_CLEAR_EN
    sweep(-1, n);
    check("busy_cycles", n, 16);
    sweep(8, n);
    check("busy_cycles_after_restart", n, 16);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_dout = '0;
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, i[AW-1:0], '0);
`else
    cycle(1, 0, 0, '0, '0);
    check("busy_tied_low", {31'b0, busy}, '0);
`endif

    // Fill with 2i+1 and read each back.
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, i[AW-1:0], 2 * i + 1);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, i[AW-1:0], '0);

    // Read-first on same-address write+read, then new data visible.
    cycle(0, 1, 1, 4'd5, 32'hDEAD_BEEF);
    cycle(0, 0, 1, 4'd5, '0);

    // Hold when read is low.
    cycle(0, 0, 1, 4'd3, '0);
    cycle(0, 0, 0, 4'd9, '0);
    cycle(0, 0, 0, 4'd9, '0);

    // Reset beats a same-cycle write.
    cycle(0, 0, 1, 4'd15, '0);
    cycle(1, 1, 0, 4'd2, 32'h1234_5678);
`ifdef SYNC_RAM_CLEAR_EN
    wait_idle();
`endif
    cycle(0, 0, 1, 4'd2, '0);

    // Write without read leaves Dout alone; later read sees it.
    cycle(0, 1, 0, 4'd7, 32'hA5A5_0001);
    cycle(0, 0, 0, 4'd7, '0);
    cycle(0, 0, 1, 4'd7, '0);

    // Randomised traffic.
    for (int k = 0; k < 400; k++)
      cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, DEPTH - 1)), $urandom);

    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
`ifndef SYNC_RAM_CLEAR_EN
    check("busy_tied_low_end", {31'b0, busy}, '0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
